exe_muldiv_ctrl: RTL and testbench

Sequencing controller and iterative datapath for RV64M multiply/divide in the execute stage. The single-cycle ALU does not handle these instructions; this block accepts one op at a time and runs a shared radix-2 shift-add multiplier / restoring divider over multiple cycles. It asserts busy to stall the pipeline and returns a 64-bit rd result through a valid/ready handshake. A pipeline flush aborts the operation in flight.

---
 rtl/exe_muldiv_ctrl.sv | 168 ++++++++++++++++
 tb/tb_exe_muldiv_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv_ctrl.sv
// ==== exe_muldiv_ctrl : RV64M multi-cycle multiply/divide (shift-add / restoring) ====
// Rev 1.0
`default_nettype none

module exe_muldiv_ctrl #(
   parameter int XLEN    = 64,
   parameter int MD_OP_W = 3
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [MD_OP_W-1:0] req_op_i,
   input  logic               req_is_word_i,
   input  logic [XLEN-1:0]    req_op1_i,
   input  logic [XLEN-1:0]    req_op2_i,
   input  logic               flush_i,
   output logic               busy_o,
   output logic               resp_valid_o,
   input  logic               resp_ready_i,
   output logic [XLEN-1:0]    resp_data_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PREP = 2'd1,
      S_CALC = 2'd2,
      S_DONE = 2'd3
   } state_e;

   localparam logic [6:0] C_CNT_DW = 7'd64;
   localparam logic [6:0] C_CNT_W  = 7'd32;

   state_e               state_q;
   logic [MD_OP_W-1:0]   op_q;
   logic                 word_q;
   logic                 neg_q;
   logic                 resp_valid_q;
   logic [XLEN-1:0]      op1_q, op2_q, b_q, resp_data_q;
   logic [2*XLEN-1:0]    acc_q;
   logic [6:0]           cnt_q;

   logic                 is_mul, is_rem, s1, s2, neg1, neg2, res_neg;
   logic                 div_zero, div_ovf;
   logic [XLEN-1:0]      e1, e2, mag1, mag2, min_v, spec_res, spec_fin;
   logic [XLEN:0]        mul_sum;
   logic [2*XLEN:0]      div_sh;
   logic [XLEN+1:0]      div_diff;
   logic [2*XLEN-1:0]    acc_d, acc_init, prod;
   logic [XLEN-1:0]      dv, raw, fin_res;

   always_comb begin
      is_mul = ~op_q[2];
      is_rem = op_q[2] & op_q[1];
      // Operand signedness: MUL/MULH/MULHSU/DIV/REM sign rs1; MUL/MULH/DIV/REM sign rs2
      s1 = is_mul ? (op_q[1:0] != 2'b11) : ~op_q[0];
      s2 = is_mul ? ~op_q[1] : ~op_q[0];

      e1 = op1_q;
      e2 = op2_q;
      if (word_q) begin
         e1 = s1 ? {{(XLEN-32){op1_q[31]}}, op1_q[31:0]} : {{(XLEN-32){1'b0}}, op1_q[31:0]};
         e2 = s2 ? {{(XLEN-32){op2_q[31]}}, op2_q[31:0]} : {{(XLEN-32){1'b0}}, op2_q[31:0]};
      end
      neg1 = s1 & e1[XLEN-1];
      neg2 = s2 & e2[XLEN-1];
      mag1 = neg1 ? -e1 : e1;
      mag2 = neg2 ? -e2 : e2;
      res_neg = is_rem ? neg1 : (neg1 ^ neg2);

      min_v    = word_q ? {{(XLEN-32){1'b1}}, 1'b1, 31'd0} : {1'b1, {(XLEN-1){1'b0}}};
      div_zero = (e2 == '0);
      div_ovf  = s1 & (e1 == min_v) & (&e2);
      spec_res = div_zero ? (is_rem ? e1 : '1) : (is_rem ? '0 : e1);
      spec_fin = word_q ? {{(XLEN-32){spec_res[31]}}, spec_res[31:0]} : spec_res;

      // Word divides pre-shift the dividend so 32 iterations consume it exactly
      acc_init = (word_q & ~is_mul) ? {{XLEN{1'b0}}, mag1[31:0], 32'd0} : {{XLEN{1'b0}}, mag1};

      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      div_sh   = {acc_q, 1'b0};
      div_diff = {1'b0, div_sh[2*XLEN:XLEN]} - {2'b00, b_q};
      if (is_mul)
         acc_d = {mul_sum, acc_q[XLEN-1:1]};
      else if (div_diff[XLEN+1:XLEN] == 2'b00)
         acc_d = {div_diff[XLEN-1:0], div_sh[XLEN-1:1], 1'b1};
      else
         acc_d = div_sh[2*XLEN-1:0];

      // After 32 shift-add steps the word product sits 32 bits up
      prod = word_q ? {32'd0, acc_d[2*XLEN-1:32]} : acc_d;
      if (neg_q)
         prod = -prod;
      dv = is_rem ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
      if (neg_q)
         dv = -dv;
      raw     = is_mul ? ((op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) : dv;
      fin_res = word_q ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         word_q       <= 1'b0;
         neg_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         op1_q        <= '0;
         op2_q        <= '0;
         b_q          <= '0;
         resp_data_q  <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
      end else if (flush_i) begin
         state_q      <= S_IDLE;
         resp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid_i) begin
                  op_q    <= req_op_i;
                  word_q  <= req_is_word_i & ((req_op_i[1:0] == 2'b00) | req_op_i[2]);
                  op1_q   <= req_op1_i;
                  op2_q   <= req_op2_i;
                  state_q <= S_PREP;
               end
            end
            S_PREP: begin
               neg_q <= res_neg;
               b_q   <= mag2;
               acc_q <= acc_init;
               cnt_q <= word_q ? C_CNT_W : C_CNT_DW;
               if (!is_mul && (div_zero || div_ovf)) begin
                  resp_data_q  <= spec_fin;
                  resp_valid_q <= 1'b1;
                  state_q      <= S_DONE;
               end else begin
                  state_q <= S_CALC;
               end
            end
            S_CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q - 7'd1;
               if (cnt_q == 7'd1) begin
                  resp_data_q  <= fin_res;
                  resp_valid_q <= 1'b1;
                  state_q      <= S_DONE;
               end
            end
            S_DONE: begin
               if (resp_ready_i) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready_o  = (state_q == S_IDLE) & ~flush_i;
   assign busy_o       = (state_q != S_IDLE);
   assign resp_valid_o = resp_valid_q;
   assign resp_data_o  = resp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_exe_muldiv_ctrl.sv
// ==== tb_exe_muldiv_ctrl : directed + random bench for exe_muldiv_ctrl ====
// Rev 1.0
`default_nettype none

module tb_exe_muldiv_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [2:0]  req_op_i = '0;
   logic        req_is_word_i = 1'b0;
   logic [63:0] req_op1_i = '0;
   logic [63:0] req_op2_i = '0;
   logic        flush_i = 1'b0;
   logic        busy_o;
   logic        resp_valid_o;
   logic        resp_ready_i = 1'b0;
   logic [63:0] resp_data_o;

   int errors = 0;
   int checks = 0;

   exe_muldiv_ctrl #(.XLEN(64), .MD_OP_W(3)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_op_i     (req_op_i),
      .req_is_word_i(req_is_word_i),
      .req_op1_i    (req_op1_i),
      .req_op2_i    (req_op2_i),
      .flush_i      (flush_i),
      .busy_o       (busy_o),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_data_o  (resp_data_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Architectural RV64M result computed with plain arithmetic
   function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] sp;
      logic [127:0]        up;
      logic [31:0]         x, y, r32;
      logic [63:0]         r;
      logic                we;
      sp = '0; up = '0; r32 = '0; r = '0;
      we = w && (op == 3'd0 || op[2]);
      x = a[31:0];
      y = b[31:0];
      case (op)
         3'd0: if (we) r32 = x * y; else r = a * b;
         3'd1: begin sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = sp[127:64]; end
         3'd2: begin sp = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); r = sp[127:64]; end
         3'd3: begin up = {64'd0, a} * {64'd0, b}; r = up[127:64]; end
         3'd4: if (we) begin
                  if (y == 0) r32 = '1;
                  else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r32 = x;
                  else r32 = $signed(x) / $signed(y);
               end else begin
                  if (b == 0) r = '1;
                  else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                  else r = $signed(a) / $signed(b);
               end
         3'd5: if (we) r32 = (y == 0) ? '1 : x / y;
               else r = (b == 0) ? '1 : a / b;
         3'd6: if (we) begin
                  if (y == 0) r32 = x;
                  else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r32 = '0;
                  else r32 = $signed(x) % $signed(y);
               end else begin
                  if (b == 0) r = a;
                  else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
                  else r = $signed(a) % $signed(b);
               end
         default: if (we) r32 = (y == 0) ? x : x % y;
                  else r = (b == 0) ? a : a % b;
      endcase
      if (we) r = {{32{r32[31]}}, r32};
      return r;
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input logic w,
                                  input logic [63:0] a, input logic [63:0] b);
      logic we, zero, ovf;
      we = w && (op == 3'd0 || op[2]);
      if (op[2]) begin
         zero = we ? (b[31:0] == 32'd0) : (b == 64'd0);
         ovf  = !op[0] && (we ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                              : (a == 64'h8000_0000_0000_0000 && b == '1));
         if (zero || ovf) return 2;
      end
      return we ? 34 : 66;
   endfunction

   task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
      @(negedge clk_i);
      check("req_ready_idle", {63'd0, req_ready_o}, 64'd1);
      req_valid_i = 1'b1; req_op_i = op; req_is_word_i = w; req_op1_i = a; req_op2_i = b;
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
   endtask

   task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input int hold, output logic [63:0] got);
      int          cyc;
      logic        ok;
      logic [63:0] held;
      issue(op, w, a, b);
      cyc = 0;
      ok  = 1'b1;
      do begin
         @(negedge clk_i);
         cyc++;
         if (busy_o !== 1'b1) ok = 1'b0;
      end while (resp_valid_o !== 1'b1 && cyc < 200);
      check("latency", 64'(cyc), 64'(exp_lat(op, w, a, b)));
      check("busy_during_op", {63'd0, ok}, 64'd1);
      check("resp_data", resp_data_o, model(op, w, a, b));
      got = resp_data_o;
      if (hold > 0) begin
         held = resp_data_o;
         ok   = 1'b1;
         repeat (hold) begin
            @(negedge clk_i);
            if (resp_valid_o !== 1'b1 || resp_data_o !== held || req_ready_o !== 1'b0) ok = 1'b0;
         end
         check("hold_stable", {63'd0, ok}, 64'd1);
      end
      resp_ready_i = 1'b1;
      @(posedge clk_i);
      #1 resp_ready_i = 1'b0;
      @(negedge clk_i);
      check("busy_after_resp", {63'd0, busy_o}, 64'd0);
      check("valid_after_resp", {63'd0, resp_valid_o}, 64'd0);
   endtask

   initial begin
      logic [63:0] got, a, b;
      logic [2:0]  op;
      logic        w, seen;
      int          cyc;

      repeat (3) @(negedge clk_i);
      check("rst_req_ready", {63'd0, req_ready_o}, 64'd1);
      check("rst_busy", {63'd0, busy_o}, 64'd0);
      check("rst_resp_valid", {63'd0, resp_valid_o}, 64'd0);
      check("rst_resp_data", resp_data_o, 64'd0);
      rst_ni = 1'b1;

      run_op(3'd0, 1'b0, 64'd7, -64'sd3, 0, got);
      check("mul_7_m3", got, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op(3'd3, 1'b0, '1, '1, 0, got);
      check("mulhu_ones", got, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op(3'd1, 1'b0, '1, '1, 0, got);
      check("mulh_ones", got, 64'd0);
      run_op(3'd2, 1'b0, '1, 64'd2, 0, got);
      check("mulhsu_m1_2", got, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op(3'd4, 1'b0, -64'sd7, 64'd2, 0, got);
      check("div_m7_2", got, -64'sd3);
      run_op(3'd6, 1'b0, -64'sd7, 64'd2, 0, got);
      check("rem_m7_2", got, -64'sd1);
      run_op(3'd5, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 0, got);
      check("divuw", got, 64'hFFFF_FFFF_8000_0000);
      run_op(3'd4, 1'b0, 64'd5, 64'd0, 0, got);
      check("div_by_zero", got, '1);
      run_op(3'd7, 1'b0, 64'd5, 64'd0, 0, got);
      check("remu_by_zero", got, 64'd5);
      run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 0, got);
      check("div_overflow", got, 64'h8000_0000_0000_0000);
      run_op(3'd6, 1'b1, 64'h8000_0000, '1, 0, got);
      check("remw_overflow", got, 64'd0);
      run_op(3'd5, 1'b0, 64'd1000, 64'd7, 10, got);
      check("divu_hold", got, 64'd142);

      // Flush in the middle of CALC
      issue(3'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd99);
      repeat (21) @(negedge clk_i);
      flush_i = 1'b1;
      #1 check("ready_low_in_flush", {63'd0, req_ready_o}, 64'd0);
      @(posedge clk_i);
      #1 flush_i = 1'b0;
      @(negedge clk_i);
      check("flush_busy", {63'd0, busy_o}, 64'd0);
      seen = 1'b0;
      repeat (80) begin
         @(negedge clk_i);
         if (resp_valid_o !== 1'b0) seen = 1'b1;
      end
      check("flush_no_resp", {63'd0, seen}, 64'd0);
      run_op(3'd0, 1'b0, 64'd3, 64'd4, 0, got);
      check("mul_after_flush", got, 64'd12);

      // Flush in DONE beats a simultaneous resp_ready
      issue(3'd4, 1'b0, 64'd5, 64'd0);
      cyc = 0;
      do begin
         @(negedge clk_i);
         cyc++;
      end while (resp_valid_o !== 1'b1 && cyc < 10);
      check("done_reached", {63'd0, resp_valid_o}, 64'd1);
      flush_i = 1'b1; resp_ready_i = 1'b1;
      @(posedge clk_i);
      #1 flush_i = 1'b0; resp_ready_i = 1'b0;
      @(negedge clk_i);
      check("flush_done_valid", {63'd0, resp_valid_o}, 64'd0);
      check("flush_done_busy", {63'd0, busy_o}, 64'd0);

      // Randomized operations against the arithmetic model
      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(0, 7));
         w  = 1'($urandom_range(0, 1));
         a  = {$urandom, $urandom};
         case ($urandom_range(0, 4))
            0:       b = 64'd0;
            1:       b = 64'($urandom_range(1, 20));
            2:       b = '1;
            default: b = {$urandom, $urandom};
         endcase
         if ($urandom_range(0, 5) == 0) a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
         run_op(op, w, a, b, 0, got);
      end

      // Reset asserted mid-calculation
      issue(3'd0, 1'b0, 64'd11, 64'd13);
      repeat (10) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check("midrst_busy", {63'd0, busy_o}, 64'd0);
      check("midrst_valid", {63'd0, resp_valid_o}, 64'd0);
      check("midrst_data", resp_data_o, 64'd0);
      check("midrst_ready", {63'd0, req_ready_o}, 64'd1);
      @(negedge clk_i);
      rst_ni = 1'b1;
      seen = 1'b0;
      repeat (80) begin
         @(negedge clk_i);
         if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
      end
      check("midrst_no_resp", {63'd0, seen}, 64'd0);
      run_op(3'd7, 1'b1, 64'hFFFF_FFFF_0000_0011, 64'd5, 0, got);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
